// File: rtl/renamed_register_file.sv
// renamed_register_file: architectural register file with per-register ROB
// rename tags. It has several combinational read ports, a same-cycle commit
// bypass, a ROB-result bypass, and a flush that drops every pending rename.
module renamed_register_file #(
    parameter int ROB_WIDTH  = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                             clockIn,
    input  logic                             resetIn,
    input  logic                             flushIn,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   readAddr,
    output logic [NUM_READ-1:0]              rdDirty,
    output logic [NUM_READ*ROB_WIDTH-1:0]    rdDep,
    output logic [NUM_READ*32-1:0]           rdValue,
    input  logic                             renameValid,
    input  logic [ADDR_WIDTH-1:0]            renameDest,
    input  logic [ROB_WIDTH-1:0]             renameRobId,
    input  logic                             commitValid,
    input  logic [ADDR_WIDTH-1:0]            commitDest,
    input  logic [31:0]                      commitValue,
    input  logic [ROB_WIDTH-1:0]             commitRobId,
    output logic [NUM_READ*ROB_WIDTH-1:0]    robQueryDep,
    input  logic [NUM_READ-1:0]              robQueryReady,
    input  logic [NUM_READ*32-1:0]           robQueryValue,
    output logic [ADDR_WIDTH:0]              pendingCount
);

    localparam int REG_COUNT = 2 ** ADDR_WIDTH;

    logic [31:0]            r_regs     [REG_COUNT];
    logic [ROB_WIDTH-1:0]   r_tag      [REG_COUNT];
    logic [REG_COUNT-1:0]   r_tagValid;

    logic                   w_commitWr;
    logic                   w_renameWr;
    logic                   w_commitClear;

    // x0 is hard-wired: neither commits nor renames ever touch it.
    assign w_commitWr    = commitValid && (commitDest != '0);
    assign w_renameWr    = renameValid && (renameDest != '0) && !flushIn;
    // A commit releases the tag only if it is the youngest producer and no new
    // producer is being attached to the same register this cycle.
    assign w_commitClear = w_commitWr && (r_tag[commitDest] == commitRobId) &&
                           !(renameValid && renameDest == commitDest);

    // State update: commit writes the value, rename attaches a tag, flush drops all tags.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            r_tagValid <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            if (w_commitWr) begin
                r_regs[commitDest] <= commitValue;
            end
            if (flushIn) begin
                r_tagValid <= '0;
            end else begin
                if (w_commitClear) begin
                    r_tagValid[commitDest] <= 1'b0;
                end
                if (w_renameWr) begin
                    r_tag[renameDest]      <= renameRobId;
                    r_tagValid[renameDest] <= 1'b1;
                end
            end
        end
    end

    // Operand read: file value, then commit bypass, then ROB bypass, else dirty.
    always_comb begin
        logic [ADDR_WIDTH-1:0] w_a;
        rdDirty = '0;
        rdDep   = '0;
        rdValue = '0;
        w_a     = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            w_a = readAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            if (w_a != '0) begin
                if (!r_tagValid[w_a]) begin
                    rdValue[p*32 +: 32] = r_regs[w_a];
                end else begin
                    rdDep[p*ROB_WIDTH +: ROB_WIDTH] = r_tag[w_a];
                    if (commitValid && commitDest == w_a && commitRobId == r_tag[w_a]) begin
                        rdValue[p*32 +: 32] = commitValue;
                    end else if (robQueryReady[p]) begin
                        rdValue[p*32 +: 32] = robQueryValue[p*32 +: 32];
                    end else begin
                        rdDirty[p] = 1'b1;
                    end
                end
            end
        end
    end

    assign robQueryDep = rdDep;

    // Number of registers currently waiting on a ROB entry.
    always_comb begin
        pendingCount = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            pendingCount = pendingCount + (ADDR_WIDTH+1)'(r_tagValid[i]);
        end
    end

endmodule

// File: tb/tb_renamed_register_file.sv
// Directed bench for renamed_register_file (default parameters: 4-bit ROB id,
// 32 registers, 2 read ports). Expected values are hand-computed constants.
module tb_renamed_register_file;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        flushIn;
    logic [9:0]  readAddr;
    logic [1:0]  rdDirty;
    logic [7:0]  rdDep;
    logic [63:0] rdValue;
    logic        renameValid;
    logic [4:0]  renameDest;
    logic [3:0]  renameRobId;
    logic        commitValid;
    logic [4:0]  commitDest;
    logic [31:0] commitValue;
    logic [3:0]  commitRobId;
    logic [7:0]  robQueryDep;
    logic [1:0]  robQueryReady;
    logic [63:0] robQueryValue;
    logic [5:0]  pendingCount;

    int n_cmp = 0;
    int n_mis = 0;

    renamed_register_file #(.ROB_WIDTH(4), .ADDR_WIDTH(5), .NUM_READ(2)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .flushIn(flushIn),
        .readAddr(readAddr), .rdDirty(rdDirty), .rdDep(rdDep), .rdValue(rdValue),
        .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
        .commitValid(commitValid), .commitDest(commitDest), .commitValue(commitValue),
        .commitRobId(commitRobId), .robQueryDep(robQueryDep),
        .robQueryReady(robQueryReady), .robQueryValue(robQueryValue),
        .pendingCount(pendingCount)
    );

    always #5 clockIn = ~clockIn;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1 time unit after it.
    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        readAddr = {a1, a0};
    endtask

    task automatic do_rename(input logic [4:0] d, input logic [3:0] id);
        renameValid = 1'b1; renameDest = d; renameRobId = id;
        step();
        renameValid = 1'b0;
    endtask

    initial begin
        resetIn = 1'b1; flushIn = 1'b0;
        renameValid = 1'b0; renameDest = '0; renameRobId = '0;
        commitValid = 1'b0; commitDest = '0; commitValue = '0; commitRobId = '0;
        robQueryReady = '0; robQueryValue = '0;
        rd(5'd0, 5'd5);
        #12;
        check_eq("rst_dirty",   32'(rdDirty), 32'h0);
        check_eq("rst_value0",  rdValue[31:0], 32'h0);
        check_eq("rst_value1",  rdValue[63:32], 32'h0);
        check_eq("rst_dep",     32'(rdDep), 32'h0);
        check_eq("rst_pending", 32'(pendingCount), 32'h0);
        resetIn = 1'b0;

        // Rename x5 -> ROB 3, then read it while the ROB has no result.
        do_rename(5'd5, 4'd3);
        rd(5'd5, 5'd0);
        #1;
        check_eq("x5_dirty",    32'(rdDirty[0]), 32'h1);
        check_eq("x5_dep",      32'(rdDep[3:0]), 32'h3);
        check_eq("x5_qdep",     32'(robQueryDep[3:0]), 32'h3);
        check_eq("x5_pending",  32'(pendingCount), 32'h1);
        // ROB bypass; port 1 reads x0 and must ignore its ROB bypass.
        robQueryReady = 2'b11; robQueryValue = {32'hBEEF, 32'h1234};
        #1;
        check_eq("x5_robbyp_dirty", 32'(rdDirty[0]), 32'h0);
        check_eq("x5_robbyp_value", rdValue[31:0], 32'h1234);
        check_eq("x0_robbyp_value", rdValue[63:32], 32'h0);
        robQueryReady = '0; robQueryValue = '0;

        // Commit bypass in the same cycle, then the tag is released.
        commitValid = 1'b1; commitDest = 5'd5; commitValue = 32'hDEAD; commitRobId = 4'd3;
        #1;
        check_eq("x5_cbyp_value", rdValue[31:0], 32'hDEAD);
        check_eq("x5_cbyp_dirty", 32'(rdDirty[0]), 32'h0);
        step();
        commitValid = 1'b0;
        #1;
        check_eq("x5_commit_pending", 32'(pendingCount), 32'h0);
        check_eq("x5_commit_value",   rdValue[31:0], 32'hDEAD);
        check_eq("x5_commit_dep",     32'(rdDep[3:0]), 32'h0);

        // x7 renamed twice; the older commit must not release it.
        do_rename(5'd7, 4'd2);
        do_rename(5'd7, 4'd6);
        rd(5'd7, 5'd0);
        commitValid = 1'b1; commitDest = 5'd7; commitValue = 32'h7777; commitRobId = 4'd2;
        #1;
        check_eq("x7_stale_nobyp", 32'(rdDirty[0]), 32'h1);
        step();
        commitValid = 1'b0;
        #1;
        check_eq("x7_stale_dirty",   32'(rdDirty[0]), 32'h1);
        check_eq("x7_stale_dep",     32'(rdDep[3:0]), 32'h6);
        check_eq("x7_stale_pending", 32'(pendingCount), 32'h1);

        // Commit and rename of x9 in one cycle: the rename wins.
        do_rename(5'd9, 4'd4);
        renameValid = 1'b1; renameDest = 5'd9; renameRobId = 4'd1;
        commitValid = 1'b1; commitDest = 5'd9; commitValue = 32'h99; commitRobId = 4'd4;
        step();
        renameValid = 1'b0; commitValid = 1'b0;
        rd(5'd9, 5'd0);
        #1;
        check_eq("x9_race_dirty",   32'(rdDirty[0]), 32'h1);
        check_eq("x9_race_dep",     32'(rdDep[3:0]), 32'h1);
        check_eq("x9_race_pending", 32'(pendingCount), 32'h2);

        // x0 ignores renames and commits.
        renameValid = 1'b1; renameDest = 5'd0; renameRobId = 4'd5;
        commitValid = 1'b1; commitDest = 5'd0; commitValue = 32'h5; commitRobId = 4'd5;
        step();
        renameValid = 1'b0; commitValid = 1'b0;
        rd(5'd0, 5'd0);
        #1;
        check_eq("x0_value",   rdValue[31:0], 32'h0);
        check_eq("x0_dirty",   32'(rdDirty), 32'h0);
        check_eq("x0_pending", 32'(pendingCount), 32'h2);

        // Three more renames, then flush with a commit and an ignored rename.
        do_rename(5'd1, 4'd1);
        do_rename(5'd2, 4'd2);
        do_rename(5'd3, 4'd3);
        #1;
        check_eq("pre_flush_pending", 32'(pendingCount), 32'h5);
        flushIn = 1'b1;
        commitValid = 1'b1; commitDest = 5'd2; commitValue = 32'h7; commitRobId = 4'd5;
        renameValid = 1'b1; renameDest = 5'd4; renameRobId = 4'd8;
        step();
        flushIn = 1'b0; commitValid = 1'b0; renameValid = 1'b0;
        rd(5'd2, 5'd4);
        #1;
        check_eq("flush_pending", 32'(pendingCount), 32'h0);
        check_eq("flush_x2",      rdValue[31:0], 32'h7);
        check_eq("flush_dirty",   32'(rdDirty), 32'h0);
        check_eq("flush_x4",      rdValue[63:32], 32'h0);
        rd(5'd7, 5'd9);
        #1;
        check_eq("flush_x7", rdValue[31:0], 32'h7777);
        check_eq("flush_x9", rdValue[63:32], 32'h99);

        // Asynchronous reset in the middle of a cycle.
        do_rename(5'd5, 4'd2);
        rd(5'd5, 5'd2);
        #1;
        check_eq("pre_arst_dirty", 32'(rdDirty[0]), 32'h1);
        resetIn = 1'b1;
        #1;
        check_eq("arst_pending", 32'(pendingCount), 32'h0);
        check_eq("arst_dirty",   32'(rdDirty), 32'h0);
        check_eq("arst_value",   32'(rdValue[31:0] | rdValue[63:32]), 32'h0);
        check_eq("arst_dep",     32'(rdDep), 32'h0);
        resetIn = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
